// File: rtl/dc_pred_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dc_pred_pkg
// Description : Shared definitions for the multi-size intra DC predictor:
//               block-size encodings, one-hot FSM state encoding and the
//               constant helper functions used to size internal datapaths.
// Revision    : 1.0  initial release
// ============================================================================
package dc_pred_pkg;

    // size_sel encodings; 2'd3 is reserved and always illegal
    localparam logic [1:0] SZ_4  = 2'd0;
    localparam logic [1:0] SZ_8  = 2'd1;
    localparam logic [1:0] SZ_16 = 2'd2;

    // One-hot controller states
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ACC  = 3'b010,
        RND  = 3'b100
    } state_t;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Accumulator width: holds 2*MAX_SIZE full-scale samples plus the
    // largest rounding offset without wrapping.
    function automatic int sum_w(input int bit_width, input int max_size);
        return bit_width + clog2(max_size) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dc_pred_fill.sv
`default_nettype none
// ============================================================================
// Module      : dc_pred_fill
// Description : Replicates one DC value across a MAX_SIZE x MAX_SIZE
//               prediction block. Purely combinational.
// Ports       : i_value  [BIT_WIDTH-1:0]                    DC value
//               o_dst    [BIT_WIDTH*MAX_SIZE*MAX_SIZE-1:0]  filled block
// Revision    : 1.0  initial release
// ============================================================================
module dc_pred_fill
    import dc_pred_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int MAX_SIZE  = 16
) (
    input  logic [BIT_WIDTH-1:0]                   i_value,
    output logic [BIT_WIDTH*MAX_SIZE*MAX_SIZE-1:0] o_dst
);

    generate
        for (genvar i = 0; i < MAX_SIZE * MAX_SIZE; i++) begin : g_fill
            assign o_dst[i*BIT_WIDTH +: BIT_WIDTH] = i_value;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dc_pred_multi.sv
`default_nettype none
// ============================================================================
// Module      : dc_pred_multi
// Description : Run-time sized (4x4 / 8x8 / 16x16) intra DC predictor.
//               Captures the neighbour edges on accept, sums LANES samples
//               per edge per cycle, applies size-correct rounding and drives
//               a replicated MAX_SIZE x MAX_SIZE prediction block.
// Ports       : clk, rst_n                clock / async active-low reset
//               start                     request, accepted only when idle
//               size_sel[1:0]             0:4x4 1:8x8 2:16x16 3:illegal
//               top_avail, left_avail     neighbour validity
//               top, left                 edge samples, sample i at [BW*i +: BW]
//               dst                       prediction block (all = dc_value)
//               dc_value                  registered DC result
//               busy                      high from accept until done cycle
//               done, err                 one-cycle result / illegal-size pulse
// Revision    : 1.0  initial release
// ============================================================================
module dc_pred_multi
    import dc_pred_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int MAX_SIZE  = 16,
    parameter int LANES     = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [1:0]                             size_sel,
    input  logic                                   top_avail,
    input  logic                                   left_avail,
    input  logic [BIT_WIDTH*MAX_SIZE-1:0]          top,
    input  logic [BIT_WIDTH*MAX_SIZE-1:0]          left,
    output logic [BIT_WIDTH*MAX_SIZE*MAX_SIZE-1:0] dst,
    output logic [BIT_WIDTH-1:0]                   dc_value,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err
);

    localparam int LOG2_MAX   = clog2(MAX_SIZE);
    localparam int LOG2_LANES = clog2(LANES);
    localparam int SUM_W      = sum_w(BIT_WIDTH, MAX_SIZE);
    localparam int STEPS_MAX  = MAX_SIZE / LANES;
    localparam int CNT_W      = (STEPS_MAX > 1) ? clog2(STEPS_MAX) : 1;
    // One extra bit so that sample indices can be compared against N itself
    localparam int IDX_W      = LOG2_MAX + 1;

    localparam logic [BIT_WIDTH-1:0] DC_MID = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    // log2(N) for a size code; the reserved code maps past any legal size
    function automatic logic [2:0] size_log2(input logic [1:0] s);
        case (s)
            SZ_4:    return 3'd2;
            SZ_8:    return 3'd3;
            SZ_16:   return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    function automatic logic size_legal(input logic [1:0] s);
        return (s != 2'd3) && (int'(size_log2(s)) <= LOG2_MAX);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q,   state_d;
    logic [1:0]             size_q,    size_d;
    logic                   top_av_q,  top_av_d;
    logic                   left_av_q, left_av_d;
    logic [BIT_WIDTH-1:0]   top_q  [MAX_SIZE];
    logic [BIT_WIDTH-1:0]   top_d  [MAX_SIZE];
    logic [BIT_WIDTH-1:0]   left_q [MAX_SIZE];
    logic [BIT_WIDTH-1:0]   left_d [MAX_SIZE];
    logic [SUM_W-1:0]       acc_q,     acc_d;
    logic [CNT_W-1:0]       count_q,   count_d;
    logic [BIT_WIDTH-1:0]   dc_q,      dc_d;
    logic                   done_q,    done_d;
    logic                   err_q,     err_d;

    // ------------------------------------------------------------------
    // Input edge unpacking
    // ------------------------------------------------------------------
    logic [BIT_WIDTH-1:0]   top_in  [MAX_SIZE];
    logic [BIT_WIDTH-1:0]   left_in [MAX_SIZE];

    generate
        for (genvar i = 0; i < MAX_SIZE; i++) begin : g_unpack
            assign top_in[i]  = top[i*BIT_WIDTH +: BIT_WIDTH];
            assign left_in[i] = left[i*BIT_WIDTH +: BIT_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode of the captured request
    // ------------------------------------------------------------------
    logic [2:0]       log2n;
    logic             illegal;
    logic             both_av;
    logic             any_av;
    logic [IDX_W-1:0] n_val;

    assign log2n   = size_log2(size_q);
    assign illegal = !size_legal(size_q);
    assign both_av = top_av_q && left_av_q;
    assign any_av  = top_av_q || left_av_q;
    // Only meaningful for legal sizes, which always fit in IDX_W bits
    assign n_val   = IDX_W'(1) << log2n;

    // ------------------------------------------------------------------
    // Lane adder: sums the current LANES-wide slice of each available
    // edge, dropping lanes that fall at or beyond N.
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] step_sum;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] idx;
    logic             last_step;

    always_comb begin
        step_sum  = '0;
        idx       = '0;
        base      = IDX_W'(count_q) << LOG2_LANES;
        // Final step when the next slice would start at or past N
        last_step = (base + IDX_W'(LANES)) >= n_val;
        for (int j = 0; j < LANES; j++) begin
            idx = base + IDX_W'(j);
            if (idx < n_val) begin
                if (top_av_q) begin
                    step_sum = step_sum + SUM_W'(top_q[idx[LOG2_MAX-1:0]]);
                end
                if (left_av_q) begin
                    step_sum = step_sum + SUM_W'(left_q[idx[LOG2_MAX-1:0]]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Rounding: both edges average 2N samples, one edge averages N.
    // ------------------------------------------------------------------
    logic [SUM_W-1:0]     rnd_add;
    logic [3:0]           shamt;
    logic [BIT_WIDTH-1:0] dc_calc;

    always_comb begin
        rnd_add = both_av ? SUM_W'(n_val) : SUM_W'(n_val >> 1);
        shamt   = {1'b0, log2n} + {3'b000, both_av};
        dc_calc = BIT_WIDTH'((acc_q + rnd_add) >> shamt);
    end

    // ------------------------------------------------------------------
    // Controller next-state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        top_av_d  = top_av_q;
        left_av_d = left_av_q;
        top_d     = top_q;
        left_d    = left_q;
        acc_d     = acc_q;
        count_d   = count_q;
        dc_d      = dc_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    size_d    = size_sel;
                    top_av_d  = top_avail;
                    left_av_d = left_avail;
                    top_d     = top_in;
                    left_d    = left_in;
                    acc_d     = '0;
                    count_d   = '0;
                    if (size_legal(size_sel) && (top_avail || left_avail)) begin
                        state_d = ACC;
                    end else begin
                        state_d = RND;
                    end
                end
            end
            ACC: begin
                acc_d = acc_q + step_sum;
                if (last_step) begin
                    count_d = '0;
                    state_d = RND;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            RND: begin
                dc_d    = (illegal || !any_av) ? DC_MID : dc_calc;
                done_d  = 1'b1;
                err_d   = illegal;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            size_q    <= 2'd0;
            top_av_q  <= 1'b0;
            left_av_q <= 1'b0;
            top_q     <= '{default: '0};
            left_q    <= '{default: '0};
            acc_q     <= '0;
            count_q   <= '0;
            dc_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            top_av_q  <= top_av_d;
            left_av_q <= left_av_d;
            top_q     <= top_d;
            left_q    <= left_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            dc_q      <= dc_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dc_value = dc_q;
    assign done     = done_q;
    assign err      = err_q;
    // Leaving RND returns to IDLE on the same edge that raises done
    assign busy     = (state_q != IDLE);

    dc_pred_fill #(
        .BIT_WIDTH (BIT_WIDTH),
        .MAX_SIZE  (MAX_SIZE)
    ) u_fill (
        .i_value (dc_q),
        .o_dst   (dst)
    );

endmodule
`default_nettype wire

// File: tb/tb_dc_pred_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_dc_pred_multi
// Description : Scoreboard bench for dc_pred_multi (BIT_WIDTH=8, MAX_SIZE=16,
//               LANES=4). A driver issues directed and random requests and
//               queues the reference result; a monitor checks each done.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dc_pred_multi;

    localparam int BW = 8;
    localparam int MS = 16;
    localparam int LN = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [1:0]          size_sel = 2'd0;
    logic                top_avail = 1'b0;
    logic                left_avail = 1'b0;
    logic [BW*MS-1:0]    top = '0;
    logic [BW*MS-1:0]    left = '0;
    logic [BW*MS*MS-1:0] dst;
    logic [BW-1:0]       dc_value;
    logic                busy;
    logic                done;
    logic                err;

    dc_pred_multi #(
        .BIT_WIDTH (BW),
        .MAX_SIZE  (MS),
        .LANES     (LN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .size_sel   (size_sel),
        .top_avail  (top_avail),
        .left_avail (left_avail),
        .top        (top),
        .left       (left),
        .dst        (dst),
        .dc_value   (dc_value),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] dc;
        logic       err;
        int         done_cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bad_samples(input logic [7:0] v);
        int bad = 0;
        for (int i = 0; i < MS * MS; i++) begin
            if (dst[i*BW +: BW] !== v) bad++;
        end
        return bad;
    endfunction

    function automatic logic [BW*MS-1:0] rand_edge();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: plain averaging over the first N samples of each used edge
    function automatic void model(input logic [1:0] sz, input logic ta, input logic la,
                                  input logic [BW*MS-1:0] t, input logic [BW*MS-1:0] l,
                                  output logic [7:0] dc, output logic e, output int lat);
        int n;
        int sum;
        bit legal;
        n     = 4 << sz;
        legal = (sz != 2'd3) && (n <= MS);
        sum   = 0;
        if (!legal || (!ta && !la)) begin
            dc  = 8'h80;
            e   = !legal;
            lat = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (ta) sum += int'(t[i*BW +: BW]);
            if (la) sum += int'(l[i*BW +: BW]);
        end
        if (ta && la) dc = 8'((sum + n) / (2 * n));
        else          dc = 8'((sum + n / 2) / n);
        e   = 1'b0;
        lat = (n + LN - 1) / LN + 1;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 with no request outstanding (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                chk("dc_value", longint'(dc_value), longint'(e.dc));
                chk("err", longint'(err), longint'(e.err));
                chk("done_cycle", longint'(cyc), longint'(e.done_cyc));
                chk("busy_at_done", longint'(busy), 0);
                chk("dst_bad_samples", longint'(bad_samples(e.dc)), 0);
            end
        end
    end

    // Driver: called at a negedge; waits for idle, raises start, keeps it
    // high for 'hold' extra cycles while scrambling inputs, then drops it.
    task automatic issue(input logic [1:0] sz, input logic ta, input logic la,
                         input logic [BW*MS-1:0] t, input logic [BW*MS-1:0] l,
                         input int hold);
        int   guard;
        exp_t e;
        int   lat;
        guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles expected 0", guard);
            return;
        end
        size_sel   = sz;
        top_avail  = ta;
        left_avail = la;
        top        = t;
        left       = l;
        start      = 1'b1;
        model(sz, ta, la, t, l, e.dc, e.err, lat);
        e.done_cyc = cyc + 1 + lat;
        sbq.push_back(e);
        @(negedge clk);
        repeat (hold) begin
            size_sel   = 2'($urandom_range(0, 3));
            top_avail  = 1'($urandom);
            left_avail = 1'($urandom);
            top        = rand_edge();
            left       = rand_edge();
            @(negedge clk);
        end
        start      = 1'b0;
        size_sel   = 2'($urandom_range(0, 3));
        top_avail  = 1'($urandom);
        left_avail = 1'($urandom);
        top        = rand_edge();
        left       = rand_edge();
    endtask

    task automatic drain();
        int g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain_outstanding", longint'(sbq.size()), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nd;
        logic [BW*MS-1:0] t4;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_dc_value", longint'(dc_value), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_err", longint'(err), 0);
        chk("rst_dst_bad_samples", longint'(bad_samples(8'h00)), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 16x16 both: (160+320+16)>>5 = 15
        issue(2'd2, 1'b1, 1'b1, {MS{8'd10}}, {MS{8'd20}}, 0);
        // 4x4 top only, upper samples 0xFF must be ignored: (10+2)>>2 = 3
        t4 = {{(MS-4){8'hFF}}, 8'd4, 8'd3, 8'd2, 8'd1};
        issue(2'd0, 1'b1, 1'b0, t4, rand_edge(), 0);
        // 8x8 left only, full scale: 255
        issue(2'd1, 1'b0, 1'b1, rand_edge(), {MS{8'hFF}}, 0);
        // No neighbours: 0x80
        issue(2'd1, 1'b0, 1'b0, rand_edge(), rand_edge(), 0);
        // Illegal size: 0x80 with err
        issue(2'd3, 1'b1, 1'b1, rand_edge(), rand_edge(), 0);
        // start held high during ACC: only one result expected
        issue(2'd2, 1'b1, 1'b1, rand_edge(), rand_edge(), 2);
        // Back-to-back pairs (each issue starts in the done cycle)
        issue(2'd2, 1'b1, 1'b0, rand_edge(), rand_edge(), 0);
        issue(2'd0, 1'b1, 1'b1, rand_edge(), rand_edge(), 0);
        drain();

        // Randomised requests with occasional idle gaps
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  rand_edge(), rand_edge(), 0);
        end
        drain();

        // Reset in the middle of ACC aborts the request
        issue(2'd2, 1'b1, 1'b1, {MS{8'd200}}, {MS{8'd100}}, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_done", longint'(done), 0);
        chk("abort_dc_value", longint'(dc_value), 0);
        chk("abort_dst_bad_samples", longint'(bad_samples(8'h00)), 0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("done_after_abort", longint'(nd), 0);

        // Recovery after reset
        issue(2'd1, 1'b1, 1'b1, rand_edge(), rand_edge(), 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
